mag_level_smoother: RTL and testbench
=====================================

# mag_level_smoother

Post-processing stage between the FFT block's 16 bin magnitudes and the 16 servo channels. It captures a frame of 64-bit bin magnitudes and compresses each bin to an 8-bit log-scale level. It removes a noise floor and applies peak-hold with linear decay, so the servos track loudness without jitter. Each processed frame updates all 16 levels at once; each servo magnitude input is driven by its level zero-extended.

## Interface
- NBINS, default 16: number of FFT bins/servo channels.
- MAG_W, default 64: magnitude width; must be a power of 2, at most 64.
- NOISE_FLOOR, default 16: log code subtracted from every bin, with saturation at 0.
- DECAY, default 4: maximum fall of a held level per frame.
- LVL_W, derived = clog2(MAG_W)+2, which is 8 at the default MAG_W: level width.
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  reset; asynchronous, active-low.
- mag_valid  in  1  one-cycle strobe: mag holds a complete new frame.
- mag  in  NBINS x MAG_W  bin magnitudes; only sampled on an accepted mag_valid.
- level  out  NBINS x LVL_W  smoothed levels, registered.
- levels_valid  out  1  one-cycle strobe: level updated this cycle.
- busy  out  1  frame in progress.
- overrun  out  1  sticky: a mag_valid arrived while busy.

## Operation
- States: IDLE, PROC, COMMIT.
- IDLE:
  - On mag_valid, copy all NBINS magnitudes into a frame buffer.
  - Clear bin index i to 0 and go to PROC.
- PROC handles one bin per cycle, bin i:
  - Find the MSB index k of buf[i].
  - Log code is code = 4k + f, where f is the two bits below the MSB.
  - For k>=2, f = buf[i][k-1:k-2].
  - For k=1, f = {buf[i][0],0}.
  - For k=0 or buf[i]==0, code = 0.
  - Floor step: c = code - NOISE_FLOOR, saturating at 0.
  - Hold update against the held value h[i]:
    - If c >= h[i], then h[i] = c (instant attack).
    - Otherwise h[i] = max(c, h[i] - DECAY), with the subtraction saturating at 0.
  - Increment i. After bin NBINS-1, go to COMMIT.
- COMMIT:
  - Copy all h[] into level[] in parallel.
  - Pulse levels_valid and return to IDLE.
- mag_valid while not in IDLE:
  - The frame is dropped and the frame being processed is unaffected.
  - overrun is set; it stays set until reset.
- mag_valid in the same cycle as the COMMIT→IDLE transition is not accepted, because the state is not IDLE in that cycle.
- level changes only in COMMIT, so servos never see a partially updated frame.

## Timing
- Reset values:
  - level = 0, h[] = 0, levels_valid = 0, busy = 0, overrun = 0, state = IDLE.
  - The frame buffer is don't-care.
- Reset is asynchronous mid-frame: all state clears immediately and no levels_valid is produced for the aborted frame.
- Accepted mag_valid sampled at edge E:
  - Buffer loaded at E.
  - Bins 0..NBINS-1 processed at edges E+1..E+NBINS.
  - level updated and levels_valid high after edge E+NBINS+1, for exactly one cycle.
  - Latency is 17 clocks for NBINS=16.
- busy is high after E and stays high until the edge that returns to IDLE, E+NBINS+1.
- The earliest next accepted frame is at edge E+NBINS+2.
- At FS=640 Hz, frames arrive far slower than 18 clocks, so overrun only signals a fault.
- MSB search is a single-cycle combinational priority encode over MAG_W bits. Its result is registered into h[i] at the PROC edge.

## Test plan
- Reset then idle:
  - Stimulus: reset_n low mid-run, then release with no mag_valid.
  - Required: level all 0; levels_valid, busy and overrun all 0.
- Log mapping:
  - Stimulus: frame with bin0 = 64'h1_0000, bin1 = 64'h1_C000, bin2 = all ones, bin3 = 0, bin4 = 64'h2.
  - Required: level[0] = 48, level[1] = 51, level[2] = 239, level[3] = 0, level[4] = 0 (code 4 floored).
  - Required: levels_valid exactly 17 cycles after mag_valid.
- Decay:
  - Stimulus: frame with bin2 = all ones, then three frames with bin2 = 0.
  - Required: level[2] = 239, then 235, 231, 227.
  - Stimulus: then a frame with bin2 = 64'h1_0000.
  - Required: level[2] = 223, because the decay value exceeds c = 48.
- Attack during decay:
  - Stimulus: with held level 100, a frame with c = 101.
  - Required: level = 101 immediately.
- Overrun:
  - Stimulus: second mag_valid 5 cycles after the first.
  - Required: ignored; levels from the first frame only; overrun = 1 and remains 1 through later good frames.
- Reset mid-frame:
  - Stimulus: assert reset_n during PROC (bin 7).
  - Required: no levels_valid pulse, level = 0, busy = 0.
  - Stimulus: the next frame.
  - Required: it processes normally with latency 17.

Source files
------------

// File: rtl/mag_level_smoother.sv
// mag_level_smoother: FFT bin magnitudes to log-scale servo levels
// with noise floor removal and peak-hold / linear decay.
module mag_level_smoother #(
  parameter int NBINS       = 16,
  parameter int MAG_W       = 64,
  parameter int NOISE_FLOOR = 16,
  parameter int DECAY       = 4,
  parameter int LVL_W       = $clog2(MAG_W) + 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mag_valid,
  input  logic [NBINS*MAG_W-1:0]   mag,
  output logic [NBINS*LVL_W-1:0]   level,
  output logic                     levels_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int KW = $clog2(MAG_W);
  localparam int IW = (NBINS > 1) ? $clog2(NBINS) : 1;

  localparam logic [IW-1:0]    LAST = IW'(NBINS - 1);
  localparam logic [LVL_W-1:0] NF   = LVL_W'(NOISE_FLOOR);
  localparam logic [LVL_W-1:0] DC   = LVL_W'(DECAY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROC,
    S_COMMIT
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [MAG_W-1:0] r_buf   [NBINS];
  logic [LVL_W-1:0] r_hold  [NBINS];
  logic [LVL_W-1:0] r_level [NBINS];
  logic             r_levels_valid;
  logic             r_busy;
  logic             r_overrun;

  logic [MAG_W-1:0] w_cur;
  logic [LVL_W-1:0] w_h_cur;
  logic [KW-1:0]    w_k;
  logic [1:0]       w_f;
  logic [LVL_W-1:0] w_code;
  logic [LVL_W-1:0] w_c;
  logic [LVL_W-1:0] w_dec;
  logic [LVL_W-1:0] w_new;

  assign w_cur   = r_buf[r_idx];
  assign w_h_cur = r_hold[r_idx];

  // Priority encode: MSB index k and the two bits below it
  always_comb begin
    w_k = '0;
    w_f = '0;
    if (w_cur[1]) begin
      w_k = KW'(1);
      w_f = {w_cur[0], 1'b0};
    end
    for (int j = 2; j < MAG_W; j++) begin
      if (w_cur[j]) begin
        w_k = KW'(j);
        w_f = {w_cur[j-1], w_cur[j-2]};
      end
    end
  end

  // 4k+f packs as {k,f}; k=0 and zero input both give 0
  assign w_code = {w_k, w_f};
  assign w_c    = (w_code > NF) ? w_code - NF : '0;
  assign w_dec  = (w_h_cur > DC) ? w_h_cur - DC : '0;
  assign w_new  = (w_c >= w_h_cur) ? w_c
                : ((w_c > w_dec) ? w_c : w_dec);

  // Frame capture on an accepted strobe; contents are don't-care otherwise
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && mag_valid) begin
      for (int b = 0; b < NBINS; b++) begin
        r_buf[b] <= mag[b*MAG_W +: MAG_W];
      end
    end
  end

  // Frame sequencer: capture, one bin per cycle, parallel commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_levels_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      for (int b = 0; b < NBINS; b++) begin
        r_hold[b]  <= '0;
        r_level[b] <= '0;
      end
    end else begin
      r_levels_valid <= 1'b0;
      if (mag_valid && r_state != S_IDLE) begin
        r_overrun <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (mag_valid) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_PROC;
          end
        end
        S_PROC: begin
          r_hold[r_idx] <= w_new;
          r_idx         <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          for (int b = 0; b < NBINS; b++) begin
            r_level[b] <= r_hold[b];
          end
          r_levels_valid <= 1'b1;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NBINS; g++) begin : g_lvl
      assign level[g*LVL_W +: LVL_W] = r_level[g];
    end
  endgenerate

  assign levels_valid = r_levels_valid;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_mag_level_smoother.sv
// tb_mag_level_smoother: randomized and directed frames checked
// against an arithmetic model of the log/floor/hold rules.
module tb_mag_level_smoother;

  localparam int NB = 16;
  localparam int MW = 64;
  localparam int LW = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              mag_valid;
  logic [NB*MW-1:0]  mag;
  logic [NB*LW-1:0]  level;
  logic              levels_valid;
  logic              busy;
  logic              overrun;

  int checks   = 0;
  int failures = 0;

  logic [63:0] fr [NB];
  int          hm [NB];

  mag_level_smoother dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mag_valid    (mag_valid),
    .mag          (mag),
    .level        (level),
    .levels_valid (levels_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lvl(input int b);
    return level[b*LW +: LW];
  endfunction

  function automatic int code_of(input logic [63:0] x);
    int k;
    int f;
    if (x == 64'd0) return 0;
    k = 0;
    while ((x >> (k + 1)) != 64'd0) k++;
    if (k >= 2) f = int'((x >> (k - 2)) & 64'd3);
    else if (k == 1) f = int'(x[0]) * 2;
    else f = 0;
    return 4 * k + f;
  endfunction

  task automatic model_apply();
    int c;
    int d;
    for (int b = 0; b < NB; b++) begin
      c = code_of(fr[b]) - 16;
      if (c < 0) c = 0;
      if (c >= hm[b]) hm[b] = c;
      else begin
        d = hm[b] - 4;
        if (d < 0) d = 0;
        hm[b] = (c > d) ? c : d;
      end
    end
  endtask

  task automatic clear_fr();
    for (int b = 0; b < NB; b++) fr[b] = 64'd0;
  endtask

  task automatic rand_fr();
    logic [63:0] v;
    for (int b = 0; b < NB; b++) begin
      v = {$urandom, $urandom};
      fr[b] = v >> $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) fr[b] = 64'd0;
    end
  endtask

  // Drive fr as one accepted frame; lat = negedges until levels_valid
  task automatic fire_and_wait(output int lat);
    @(negedge clk);
    for (int b = 0; b < NB; b++) mag[b*MW +: MW] = fr[b];
    mag_valid = 1'b1;
    @(negedge clk);
    mag_valid = 1'b0;
    model_apply();
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      if (levels_valid) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int pulses;
    clear_fr();
    fr[0] = 64'hFFFF;
    @(negedge clk);
    for (int b = 0; b < NB; b++) mag[b*MW +: MW] = fr[b];
    mag_valid = 1'b1;
    @(negedge clk);
    mag_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int b = 0; b < NB; b++) hm[b] = 0;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (levels_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL reset_no_pulse: got %0d want 0", pulses);
    end
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0 || levels_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got busy=%b ovr=%b lv=%b want 0",
               busy, overrun, levels_valid);
    end
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (lvl(b) !== 8'd0) begin
        failures++;
        $display("FAIL reset_level[%0d]: got %0d want 0", b, lvl(b));
      end
    end
  endtask

  task automatic test_log_mapping();
    int lat;
    logic [7:0] exp_c [5];
    exp_c = '{8'd48, 8'd51, 8'd239, 8'd0, 8'd0};
    clear_fr();
    fr[0] = 64'h1_0000;
    fr[1] = 64'h1_C000;
    fr[2] = '1;
    fr[3] = 64'h0;
    fr[4] = 64'h2;
    fr[5] = 64'h3;
    fr[6] = 64'h1F_FFFF;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy: got %b want 0", busy);
    end
    fire_and_wait(lat);
    checks++;
    if (lat !== 17) begin
      failures++;
      $display("FAIL map_latency: got %0d want 17", lat);
    end
    for (int b = 0; b < 5; b++) begin
      checks++;
      if (lvl(b) !== exp_c[b]) begin
        failures++;
        $display("FAIL map_level[%0d]: got %0d want %0d",
                 b, lvl(b), exp_c[b]);
      end
    end
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (lvl(b) !== 8'(hm[b])) begin
        failures++;
        $display("FAIL map_model[%0d]: got %0d want %0d",
                 b, lvl(b), hm[b]);
      end
    end
    @(negedge clk);
    checks++;
    if (levels_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL map_one_pulse: got lv=%b busy=%b want 0 0",
               levels_valid, busy);
    end
  endtask

  task automatic test_decay();
    int lat;
    logic [7:0] exp_d [5];
    exp_d = '{8'd239, 8'd235, 8'd231, 8'd227, 8'd223};
    for (int s = 0; s < 5; s++) begin
      clear_fr();
      if (s == 0) fr[2] = '1;
      if (s == 4) fr[2] = 64'h1_0000;
      fire_and_wait(lat);
      checks++;
      if (lat !== 17) begin
        failures++;
        $display("FAIL decay_latency%0d: got %0d want 17", s, lat);
      end
      checks++;
      if (lvl(2) !== exp_d[s]) begin
        failures++;
        $display("FAIL decay_step%0d: got %0d want %0d",
                 s, lvl(2), exp_d[s]);
      end
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (lvl(b) !== 8'(hm[b])) begin
          failures++;
          $display("FAIL decay_model%0d[%0d]: got %0d want %0d",
                   s, b, lvl(b), hm[b]);
        end
      end
    end
  endtask

  task automatic test_attack();
    int lat;
    clear_fr();
    fr[5] = 64'd1 << 29;
    fire_and_wait(lat);
    checks++;
    if (lvl(5) !== 8'd100) begin
      failures++;
      $display("FAIL attack_setup: got %0d want 100", lvl(5));
    end
    clear_fr();
    fr[5] = (64'd1 << 29) | (64'd1 << 27);
    fire_and_wait(lat);
    checks++;
    if (lvl(5) !== 8'd101) begin
      failures++;
      $display("FAIL attack_101: got %0d want 101", lvl(5));
    end
    checks++;
    if (lvl(5) !== 8'(hm[5])) begin
      failures++;
      $display("FAIL attack_model: got %0d want %0d", lvl(5), hm[5]);
    end
  endtask

  task automatic test_random();
    int lat;
    for (int s = 0; s < 8; s++) begin
      rand_fr();
      fire_and_wait(lat);
      checks++;
      if (lat !== 17) begin
        failures++;
        $display("FAIL rand_latency%0d: got %0d want 17", s, lat);
      end
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (lvl(b) !== 8'(hm[b])) begin
          failures++;
          $display("FAIL rand_model%0d[%0d]: got %0d want %0d",
                   s, b, lvl(b), hm[b]);
        end
      end
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL rand_no_overrun: got %b want 0", overrun);
    end
  endtask

  task automatic test_overrun();
    int lat;
    rand_fr();
    @(negedge clk);
    for (int b = 0; b < NB; b++) mag[b*MW +: MW] = fr[b];
    mag_valid = 1'b1;
    @(negedge clk);
    mag_valid = 1'b0;
    model_apply();
    repeat (4) @(negedge clk);
    for (int b = 0; b < NB; b++) mag[b*MW +: MW] = '1;
    mag_valid = 1'b1;
    @(negedge clk);
    mag_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set: got %b want 1", overrun);
    end
    lat = -1;
    for (int n = 5; n < 40; n++) begin
      if (levels_valid) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat !== 17) begin
      failures++;
      $display("FAIL ovr_latency: got %0d want 17", lat);
    end
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (lvl(b) !== 8'(hm[b])) begin
        failures++;
        $display("FAIL ovr_model[%0d]: got %0d want %0d",
                 b, lvl(b), hm[b]);
      end
    end
    rand_fr();
    fire_and_wait(lat);
    checks++;
    if (lat !== 17) begin
      failures++;
      $display("FAIL ovr_next_latency: got %0d want 17", lat);
    end
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_sticky: got %b want 1", overrun);
    end
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (lvl(b) !== 8'(hm[b])) begin
        failures++;
        $display("FAIL ovr_next_model[%0d]: got %0d want %0d",
                 b, lvl(b), hm[b]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int lat;
    int pulses;
    int bad;
    rand_fr();
    fr[0] = '1;
    @(negedge clk);
    for (int b = 0; b < NB; b++) mag[b*MW +: MW] = fr[b];
    mag_valid = 1'b1;
    @(negedge clk);
    mag_valid = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    bad = 0;
    for (int b = 0; b < NB; b++) if (lvl(b) !== 8'd0) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL mid_rst_level: got %0d nonzero want 0", bad);
    end
    checks++;
    if (busy !== 1'b0 || levels_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_flags: got busy=%b lv=%b ovr=%b want 0",
               busy, levels_valid, overrun);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int b = 0; b < NB; b++) hm[b] = 0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (levels_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL mid_rst_no_pulse: got %0d want 0", pulses);
    end
    rand_fr();
    fire_and_wait(lat);
    checks++;
    if (lat !== 17) begin
      failures++;
      $display("FAIL mid_rst_latency: got %0d want 17", lat);
    end
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (lvl(b) !== 8'(hm[b])) begin
        failures++;
        $display("FAIL mid_rst_model[%0d]: got %0d want %0d",
                 b, lvl(b), hm[b]);
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    mag_valid = 1'b0;
    mag       = '0;
    for (int b = 0; b < NB; b++) hm[b] = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_log_mapping();
    test_decay();
    test_attack();
    test_random();
    test_overrun();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
